// File: rtl/pq_pkg.sv
// pq_pkg: shared key/value entry type, queue constants, op encoding and ordering helper
package pq_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
  localparam int PQ_CAPACITY = 4;
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;
  localparam logic [KEY_WIDTH-1:0] KEYINF = '1;
  localparam logic [KEY_WIDTH-1:0] KEY0 = '0;
  localparam logic [VAL_WIDTH-1:0] VAL0 = '0;
  localparam kv_t KV_EMPTY = '{key: KEYINF, val: VAL0};
  typedef enum logic [1:0] {PQ_NOP, PQ_ENQ, PQ_DEQ, PQ_REPL} pq_op_t;
  // 1 when a strictly beats b; ties never win, which keeps equal keys in FIFO order
  function automatic logic kv_better(kv_t a, kv_t b, logic max_first);
    return max_first ? (a.key > b.key) : (a.key < b.key);
  endfunction
endpackage

// File: rtl/pq_shift_array_if.sv
// pq_shift_array_if: HWPQ handshake bundle; hwm exists only when PQ_STATS_EN is defined
interface pq_shift_array_if
  import pq_pkg::*;
#(
  parameter int CW = $clog2(PQ_CAPACITY + 1)
) ();
  logic enq;
  logic deq;
  kv_t enq_kv;
  kv_t head_kv;
  logic head_valid;
  logic full;
  logic empty;
  logic [CW-1:0] count;
  logic ovf_err;
`ifdef PQ_STATS_EN
  logic [CW-1:0] hwm;
`endif
  modport master (
    output enq, deq, enq_kv,
    input head_kv, head_valid, full, empty, count, ovf_err
`ifdef PQ_STATS_EN
    , input hwm
`endif
  );
  modport slave (
    input enq, deq, enq_kv,
    output head_kv, head_valid, full, empty, count, ovf_err
`ifdef PQ_STATS_EN
    , output hwm
`endif
  );
endinterface

// File: rtl/pq_shift_cell.sv
// pq_shift_cell: one queue slot choosing its next entry from left, self, right or the new entry
module pq_shift_cell
  import pq_pkg::*;
#(
  parameter bit MAX_FIRST = 1'b0,
  parameter bit HEAD = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  pq_op_t op,
  input  kv_t    enq_kv,
  input  kv_t    left_kv,
  input  logic   left_v,
  input  logic   left_ins,
  input  kv_t    right_kv,
  input  logic   right_v,
  input  logic   right_ins,
  output logic   ins,
  output kv_t    kv_q,
  output logic   v_q
);
  kv_t kv_d;
  logic v_d;
  logic take_enq;
  logic take_left;
  logic take_right;
  // ins marks "new entry belongs at or before this slot"; it is monotonic along the array,
  // so the insert point is where a cell sees ins set and its neighbour's ins clear
  always_comb begin
    ins = !v_q || kv_better(enq_kv, kv_q, MAX_FIRST);
    take_enq = (op == PQ_ENQ && ins && !left_ins) ||
               (op == PQ_REPL && right_ins && (HEAD || !ins));
    take_left = op == PQ_ENQ && left_ins;
    take_right = op == PQ_DEQ || (op == PQ_REPL && !right_ins);
    kv_d = take_enq ? enq_kv : take_left ? left_kv : take_right ? right_kv : kv_q;
    v_d = take_enq ? 1'b1 : take_left ? left_v : take_right ? right_v : v_q;
  end
  // slot register, cleared to an invalid empty entry on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kv_q <= KV_EMPTY;
      v_q <= 1'b0;
    end else begin
      kv_q <= kv_d;
      v_q <= v_d;
    end
  end
endmodule

// File: rtl/pq_shift_array.sv
// pq_shift_array: shift-register priority queue; define PQ_STATS_EN to add the hwm high-water mark
module pq_shift_array
  import pq_pkg::*;
#(
  parameter int CAPACITY = PQ_CAPACITY,
  parameter bit MAX_FIRST = 1'b0,
  parameter int CW = $clog2(CAPACITY + 1)
) (
  input logic clk,
  input logic rst_n,
  pq_shift_array_if.slave bus
);
  pq_op_t op;
  kv_t slot_kv [CAPACITY];
  logic slot_v [CAPACITY];
  logic slot_ins [CAPACITY];
  logic [CW-1:0] count_d, count_q;
  logic full_d, full_q, empty_d, empty_q, ovf_d, ovf_q;
  // decode the sampled request into one array-wide operation and the next status
  always_comb begin
    op = (bus.enq && bus.deq && !empty_q) ? PQ_REPL :
         (bus.enq && !full_q) ? PQ_ENQ :
         (bus.deq && !bus.enq && !empty_q) ? PQ_DEQ : PQ_NOP;
    count_d = op == PQ_ENQ ? count_q + 1'b1 : op == PQ_DEQ ? count_q - 1'b1 : count_q;
    full_d = count_d == CW'(CAPACITY);
    empty_d = count_d == '0;
    ovf_d = bus.enq && !bus.deq && full_q;
  end
  // registered status flags so every output comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      ovf_q <= ovf_d;
    end
  end
  for (genvar i = 0; i < CAPACITY; i++) begin : g_slot
    kv_t l_kv, r_kv;
    logic l_v, l_ins, r_v, r_ins;
    if (i == 0) begin : g_head
      assign l_kv = KV_EMPTY;
      assign l_v = 1'b0;
      assign l_ins = 1'b0;
    end else begin : g_left
      assign l_kv = slot_kv[i-1];
      assign l_v = slot_v[i-1];
      assign l_ins = slot_ins[i-1];
    end
    if (i == CAPACITY - 1) begin : g_tail
      assign r_kv = KV_EMPTY;
      assign r_v = 1'b0;
      assign r_ins = 1'b1;
    end else begin : g_right
      assign r_kv = slot_kv[i+1];
      assign r_v = slot_v[i+1];
      assign r_ins = slot_ins[i+1];
    end
    pq_shift_cell #(.MAX_FIRST(MAX_FIRST), .HEAD(i == 0)) u_cell (
      .clk(clk), .rst_n(rst_n), .op(op), .enq_kv(bus.enq_kv),
      .left_kv(l_kv), .left_v(l_v), .left_ins(l_ins),
      .right_kv(r_kv), .right_v(r_v), .right_ins(r_ins),
      .ins(slot_ins[i]), .kv_q(slot_kv[i]), .v_q(slot_v[i])
    );
  end
  assign bus.head_kv = slot_kv[0];
  assign bus.head_valid = slot_v[0];
  assign bus.count = count_q;
  assign bus.full = full_q;
  assign bus.empty = empty_q;
  assign bus.ovf_err = ovf_q;
`ifdef PQ_STATS_EN
  logic [CW-1:0] hwm_d, hwm_q;
  // peak occupancy, following the count that will be visible after this edge
  always_comb hwm_d = count_d > hwm_q ? count_d : hwm_q;
  // high-water mark register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_q <= '0;
    else hwm_q <= hwm_d;
  end
  assign bus.hwm = hwm_q;
`endif
endmodule

// File: tb/tb_pq_shift_array.sv
// tb_pq_shift_array: scenario tasks plus randomized traffic checked against a sorted-list model
module tb_pq_shift_array;
  import pq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  kv_t q0[$];
  kv_t q1[$];
  logic exp_ovf0, exp_ovf1;
  int hwm_m;
  always #5 clk = ~clk;
  pq_shift_array_if bus0 ();
  pq_shift_array_if bus1 ();
  pq_shift_array #(.CAPACITY(4), .MAX_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pq_shift_array #(.CAPACITY(4), .MAX_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  function automatic kv_t mk(int k, int v);
    return '{key: 8'(k), val: 8'(v)};
  endfunction

  // model: a list ordered best-first; a new entry goes before the first strictly worse one
  task automatic apply(input bit mf, input logic e, input logic d, input kv_t kv);
    kv_t q[$];
    logic ovf;
    int pos;
    if (mf) q = q1; else q = q0;
    ovf = 1'b0;
    pos = -1;
    if (d && q.size() > 0) begin
      void'(q.pop_front());
      pos = e ? q.size() : -1;
    end else if (e) begin
      if (q.size() < 4) pos = q.size();
      else ovf = 1'b1;
    end
    if (pos >= 0) begin
      for (int i = 0; i < q.size(); i++)
        if (mf ? (kv.key > q[i].key) : (kv.key < q[i].key)) begin
          pos = i;
          break;
        end
      q.insert(pos, kv);
    end
    if (mf) begin q1 = q; exp_ovf1 = ovf; end
    else begin q0 = q; exp_ovf0 = ovf; end
  endtask

  task automatic step(input logic e, input logic d, input kv_t kv);
    @(negedge clk);
    bus0.enq = e; bus0.deq = d; bus0.enq_kv = kv;
    bus1.enq = e; bus1.deq = d; bus1.enq_kv = kv;
    apply(1'b0, e, d, kv);
    apply(1'b1, e, d, kv);
    if (q0.size() > hwm_m) hwm_m = q0.size();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus0.enq = 0; bus0.deq = 0; bus0.enq_kv = KV_EMPTY;
    bus1.enq = 0; bus1.deq = 0; bus1.enq_kv = KV_EMPTY;
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    exp_ovf0 = 0; exp_ovf1 = 0; hwm_m = 0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus0.count); end
    checks++; if (bus0.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", bus0.empty); end
    checks++; if (bus0.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", bus0.full); end
    checks++; if (bus0.head_valid !== 1'b0) begin failures++; $display("FAIL reset_head_valid got=%b want=0", bus0.head_valid); end
    checks++; if (bus0.head_kv !== KV_EMPTY) begin failures++; $display("FAIL reset_head_kv got=%h want=%h", bus0.head_kv, KV_EMPTY); end
    checks++; if (bus0.ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", bus0.ovf_err); end
`ifdef PQ_STATS_EN
    checks++; if (bus0.hwm !== 3'd0) begin failures++; $display("FAIL reset_hwm got=%0d want=0", bus0.hwm); end
`endif
    do_reset();
  endtask

  task automatic test_fill_drain();
    int exp_k[4] = '{3, 5, 7, 9};
    do_reset();
    step(1, 0, mk(7, 0)); step(1, 0, mk(3, 0)); step(1, 0, mk(9, 0)); step(1, 0, mk(5, 0));
    checks++; if (bus0.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b want=1", bus0.full); end
    checks++; if (bus0.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d want=4", bus0.count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus0.head_kv.key !== 8'(exp_k[i])) begin failures++; $display("FAIL drain_key[%0d] got=%0d want=%0d", i, bus0.head_kv.key, exp_k[i]); end
      step(0, 1, KV_EMPTY);
    end
    checks++; if (bus0.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b want=1", bus0.empty); end
    checks++; if (bus0.head_kv !== KV_EMPTY) begin failures++; $display("FAIL drain_head got=%h want=%h", bus0.head_kv, KV_EMPTY); end
  endtask

  task automatic test_overflow_replace();
    int exp_k[4] = '{5, 6, 7, 9};
    do_reset();
    step(1, 0, mk(3, 0)); step(1, 0, mk(5, 0)); step(1, 0, mk(7, 0)); step(1, 0, mk(9, 0));
    step(1, 0, mk(1, 0));
    checks++; if (bus0.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b want=1", bus0.ovf_err); end
    checks++; if (bus0.head_kv.key !== 8'd3) begin failures++; $display("FAIL ovf_head got=%0d want=3", bus0.head_kv.key); end
    step(0, 0, KV_EMPTY);
    checks++; if (bus0.ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_once got=%b want=0", bus0.ovf_err); end
    step(1, 1, mk(6, 0));
    checks++; if (bus0.ovf_err !== 1'b0) begin failures++; $display("FAIL repl_ovf got=%b want=0", bus0.ovf_err); end
    checks++; if (bus0.count !== 3'd4) begin failures++; $display("FAIL repl_count got=%0d want=4", bus0.count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus0.head_kv.key !== 8'(exp_k[i])) begin failures++; $display("FAIL repl_key[%0d] got=%0d want=%0d", i, bus0.head_kv.key, exp_k[i]); end
      step(0, 1, KV_EMPTY);
    end
  endtask

  task automatic test_fifo_ties();
    kv_t exp_kv[4];
    exp_kv[0] = mk(2, 'hC3); exp_kv[1] = mk(5, 'hA1); exp_kv[2] = mk(5, 'hB2); exp_kv[3] = mk(255, 'h44);
    do_reset();
    step(1, 0, mk(5, 'hA1)); step(1, 0, mk(5, 'hB2)); step(1, 0, mk(2, 'hC3)); step(1, 0, mk(255, 'h44));
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus0.head_kv !== exp_kv[i] || bus0.head_valid !== 1'b1)
        begin failures++; $display("FAIL tie_order[%0d] got=%h/%b want=%h/1", i, bus0.head_kv, bus0.head_valid, exp_kv[i]); end
      step(0, 1, KV_EMPTY);
    end
    checks++; if (bus0.empty !== 1'b1) begin failures++; $display("FAIL tie_empty got=%b want=1", bus0.empty); end
  endtask

  task automatic test_empty_ops();
    do_reset();
    step(1, 1, mk(4, 0));
    checks++; if (bus0.count !== 3'd1) begin failures++; $display("FAIL empty_repl_count got=%0d want=1", bus0.count); end
    checks++; if (bus0.head_kv.key !== 8'd4) begin failures++; $display("FAIL empty_repl_key got=%0d want=4", bus0.head_kv.key); end
    step(0, 1, KV_EMPTY);
    step(0, 1, KV_EMPTY);
    checks++; if (bus0.count !== 3'd0) begin failures++; $display("FAIL deq_empty_count got=%0d want=0", bus0.count); end
    checks++; if (bus0.ovf_err !== 1'b0) begin failures++; $display("FAIL deq_empty_ovf got=%b want=0", bus0.ovf_err); end
  endtask

  task automatic test_max_first();
    int exp_k[3] = '{9, 7, 3};
    do_reset();
    step(1, 0, mk(7, 0)); step(1, 0, mk(3, 0)); step(1, 0, mk(9, 0));
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus1.head_kv.key !== 8'(exp_k[i])) begin failures++; $display("FAIL max_key[%0d] got=%0d want=%0d", i, bus1.head_kv.key, exp_k[i]); end
      step(0, 1, KV_EMPTY);
    end
  endtask

  task automatic test_random();
    kv_t e0, e1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int pe = ((i / 100) % 2 == 0) ? 65 : 35;
      logic e = 1'($urandom_range(0, 99) < pe);
      logic d = 1'($urandom_range(0, 99) < 100 - pe);
      int k = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 12));
      step(e, d, mk(k, int'($urandom_range(0, 255))));
      e0 = q0.size() > 0 ? q0[0] : KV_EMPTY;
      e1 = q1.size() > 0 ? q1[0] : KV_EMPTY;
      checks++; if (bus0.head_kv !== e0) begin failures++; $display("FAIL rnd_head0 cyc=%0d got=%h want=%h", i, bus0.head_kv, e0); end
      checks++; if (bus1.head_kv !== e1) begin failures++; $display("FAIL rnd_head1 cyc=%0d got=%h want=%h", i, bus1.head_kv, e1); end
      checks++; if (bus0.count !== 3'(q0.size())) begin failures++; $display("FAIL rnd_count0 cyc=%0d got=%0d want=%0d", i, bus0.count, q0.size()); end
      checks++; if (bus1.count !== 3'(q1.size())) begin failures++; $display("FAIL rnd_count1 cyc=%0d got=%0d want=%0d", i, bus1.count, q1.size()); end
      checks++; if (bus0.head_valid !== (q0.size() > 0) || bus0.empty !== (q0.size() == 0) || bus0.full !== (q0.size() == 4))
        begin failures++; $display("FAIL rnd_flags cyc=%0d got=v%b e%b f%b size=%0d", i, bus0.head_valid, bus0.empty, bus0.full, q0.size()); end
      checks++; if (bus0.ovf_err !== exp_ovf0 || bus1.ovf_err !== exp_ovf1)
        begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b%b want=%b%b", i, bus0.ovf_err, bus1.ovf_err, exp_ovf0, exp_ovf1); end
`ifdef PQ_STATS_EN
      checks++; if (bus0.hwm !== 3'(hwm_m)) begin failures++; $display("FAIL rnd_hwm cyc=%0d got=%0d want=%0d", i, bus0.hwm, hwm_m); end
`endif
    end
  endtask

  task automatic test_stats_async_reset();
    do_reset();
    step(1, 0, mk(1, 0)); step(1, 0, mk(2, 0)); step(1, 0, mk(3, 0));
    step(0, 1, KV_EMPTY); step(0, 1, KV_EMPTY); step(1, 0, mk(4, 0));
`ifdef PQ_STATS_EN
    checks++; if (bus0.hwm !== 3'd3) begin failures++; $display("FAIL stats_hwm got=%0d want=3", bus0.hwm); end
`endif
    checks++; if (bus0.count !== 3'd2) begin failures++; $display("FAIL pre_reset_count got=%0d want=2", bus0.count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus0.count !== 3'd0) begin failures++; $display("FAIL async_count got=%0d want=0", bus0.count); end
    checks++; if (bus0.empty !== 1'b1 || bus0.head_valid !== 1'b0) begin failures++; $display("FAIL async_empty got=e%b v%b want=e1 v0", bus0.empty, bus0.head_valid); end
`ifdef PQ_STATS_EN
    checks++; if (bus0.hwm !== 3'd0) begin failures++; $display("FAIL async_hwm got=%0d want=0", bus0.hwm); end
`endif
    do_reset();
  endtask

  initial begin
    bus0.enq = 0; bus0.deq = 0; bus0.enq_kv = KV_EMPTY;
    bus1.enq = 0; bus1.deq = 0; bus1.enq_kv = KV_EMPTY;
    exp_ovf0 = 0; exp_ovf1 = 0; hwm_m = 0;
    test_reset();
    test_fill_drain();
    test_overflow_replace();
    test_fifo_ties();
    test_empty_ops();
    test_max_first();
    test_random();
    test_stats_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pq_shift_array.md
# pq_shift_array

Parametrised shift-register hardware priority queue holding `pq_pkg::kv_t` entries in sorted order. It is the generalised successor to the fixed-capacity HWPQ: configurable depth, selectable min-first or max-first ordering, and simultaneous enqueue and dequeue (replace) in one cycle. It sits behind the standard HWPQ handshake and is the baseline implementation that other HWPQ variants are compared against.

## Interface
- `CAPACITY`, default `pq_pkg::PQ_CAPACITY` (4): number of entries, ≥2.
- `MAX_FIRST`, default 0: 0 places the smallest key at the head; 1 places the largest key at the head.
- `CW`, default `$clog2(CAPACITY+1)`: width of the count.
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `enq  in  1`: enqueue request.
- `enq_kv  in  kv_t`: entry to insert.
- `deq  in  1`: dequeue request; removes the head.
- `head_kv  out  kv_t`: current head entry; `KV_EMPTY` when empty.
- `head_valid  out  1`: queue is non-empty.
- `full  out  1`: count == CAPACITY.
- `empty  out  1`: count == 0.
- `count  out  CW`: number of stored entries.
- `ovf_err  out  1`: one-cycle pulse when an enqueue is dropped.
- `hwm  out  CW`: high-water mark of `count`. Present only with `PQ_STATS_EN`.

## Operation
- Storage is CAPACITY slots, each holding a kv_t and a valid bit. Valid slots are contiguous from slot 0.
- Slots are kept sorted: "better" means strictly smaller key (MAX_FIRST=0) or strictly larger key (MAX_FIRST=1).
- Equal keys keep FIFO order: a new entry is inserted behind all existing entries with an equal key.
- Emptiness comes from the valid bits only. Any key value, including KEYINF and KEY0, is a legal stored key.
- Per-cycle actions, decided on the sampled `enq`, `deq`, `count`:
  - enq only, not full: insert at the sorted position; worse entries shift one slot toward the tail; count+1.
  - enq only, full: no state change; `ovf_err`=1 for one cycle.
  - deq only, not empty: slot 0 is dropped; all entries shift one slot toward the head; the tail slot becomes invalid; count−1.
  - deq only, empty: ignored; no error.
  - enq+deq, not empty (replace, including when full): the head is removed and the new entry is inserted in sorted order among the remaining entries; count unchanged; no `ovf_err`.
  - enq+deq, empty: the deq is ignored and the enq is performed; count becomes 1.
  - neither: hold.
- Each slot's next value depends only on itself, its two neighbours, `enq_kv`, the control signals and local compare results. There is no global priority encoder and no multi-cycle state machine.
- `ovf_err` is registered.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all slots invalid, with data `KV_EMPTY`;
  - `count`=0, `empty`=1, `full`=0, `head_valid`=0, `head_kv`=`KV_EMPTY`, `ovf_err`=0, `hwm`=0.
- Reset asserted mid-operation discards all entries immediately.
- `head_kv`, `head_valid`, `full`, `empty` and `count` are driven directly from registers.
- The effect of an operation sampled at edge N is visible after edge N: an enqueue into an empty queue appears on `head_kv` in the next cycle.
- Throughput: one operation (enq, deq or replace) every cycle, with no stall and no ready signal.
- Producers must use `full` and consumers `empty`/`head_valid` as the handshake. Requests issued against these flags are handled as defined above.

## Configuration
- `PQ_STATS_EN` defined:
  - `hwm` port exists;
  - `hwm` is a register updated each cycle to max(`hwm`, next count);
  - `hwm` is cleared only by reset.
- `PQ_STATS_EN` undefined: no `hwm` port and no stats logic. All other behaviour is identical.

## Structure
- `pq_pkg` supplies `kv_t`, `KEY_WIDTH`, `VAL_WIDTH`, `KEYINF`, `KEY0`, `VAL0`, `KV_EMPTY` and `PQ_CAPACITY`.
- Add to `pq_pkg`:
  - `typedef enum logic [1:0] {PQ_NOP, PQ_ENQ, PQ_DEQ, PQ_REPL} pq_op_t`;
  - function `kv_better(a, b, max_first)`, returning 1 when a strictly beats b.
- Sub-module `pq_shift_cell`: one slot (register, valid bit, comparator, next-value mux from left, self, right or `enq_kv`). It is instantiated CAPACITY times in a generate loop. The edge cells tie their missing neighbour to invalid/`KV_EMPTY`.

## Test plan
All scenarios use CAPACITY=4 and MAX_FIRST=0 unless stated.
- Reset, then enq keys 7, 3, 9, 5 on consecutive cycles → `full`=1, `count`=4, then 4 deqs yield keys 3, 5, 7, 9, then `empty`=1 and `head_kv`=`KV_EMPTY`.
- Full queue {3, 5, 7, 9}, enq key 1 alone → `ovf_err` pulses once and contents are unchanged. Then enq key 6 together with deq → queue {5, 6, 7, 9}, `count`=4, no `ovf_err`.
- Enq (5, val A), (5, val B), (2, val C) → deq order C, A, B. Also enq key `KEYINF` → it is stored and dequeued as valid.
- Empty queue, enq key 4 together with deq → `count`=1, `head_kv` key 4. Deq on empty → no change and `ovf_err`=0.
- MAX_FIRST=1: enq 7, 3, 9 → deq order 9, 7, 3.
- With `PQ_STATS_EN`: enq ×3, deq ×2, enq ×1 → `hwm`=3. Then assert `rst_n`=0 mid-stream → `hwm`=0, `count`=0 and `empty`=1 without waiting for a clock edge.
